risc_fetch: RTL and testbench

- Instruction fetch unit that supplies the 13-bit instruction stream consumed by risc_decode.
- Holds the program counter and drives a fixed-latency synchronous instruction memory.
- Buffers returned words in a 2-entry prefetch FIFO and presents the head word to decode.
- Supports a downstream stall and a branch/jump redirect that flushes everything in flight.

---
 rtl/risc_pkg.sv | 21 ++
 rtl/risc_fetch_if.sv | 25 ++
 rtl/risc_fetch_fifo.sv | 67 ++++++
 rtl/risc_fetch.sv | 101 ++++++++++
 tb/tb_risc_fetch.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the risc fetch/decode slice.
// Optional RISC_FETCH_HALT_EN adds the HALT fetch state.
package risc_pkg;

   localparam int unsigned IW_DEF = 13;
   localparam int unsigned AW_DEF = 8;

   localparam logic [3:0]  OP_LD     = 4'b1110;
   localparam logic [3:0]  OP_ST     = 4'b1111;
   localparam logic [12:0] HALT_WORD = 13'h1FFF;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1
`ifdef RISC_FETCH_HALT_EN
      ,
      ST_HALT = 2'd2
`endif
   } fetch_state_e;

endpackage

// File: rtl/risc_fetch_if.sv
// Fetch-side bundle: instruction memory port plus decode handshake.
interface risc_fetch_if #(
   parameter int unsigned IW = risc_pkg::IW_DEF,
   parameter int unsigned AW = risc_pkg::AW_DEF
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          stall;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic [AW-1:0] instr_pc;

   modport master (
      output imem_req, imem_addr, instr, instr_valid, instr_pc,
      input  imem_rdata, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, instr_pc,
      output imem_rdata, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/risc_fetch_fifo.sv
// 2-entry prefetch FIFO; entry 0 is always the head, flush beats push.
module risc_fetch_fifo
   import risc_pkg::*;
#(
   parameter int unsigned W = IW_DEF + AW_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic [1:0]   count
);
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_pop, do_push;

   assign do_pop  = pop & (cnt_q != 2'd0);
   assign do_push = push & ~((cnt_q == 2'd2) & ~do_pop);

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = wdata;
               else               e1_d = wdata;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  e0_d = wdata;
               end else begin
                  e0_d = e1_q;
                  e1_d = wdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = e0_q;
   assign count = cnt_q;
endmodule

// File: rtl/risc_fetch.sv
// Instruction fetch: PC, 1-cycle-latency imem requests, 2-deep prefetch FIFO.
// Define RISC_FETCH_HALT_EN to stop fetching after an all-ones word.
module risc_fetch
   import risc_pkg::*;
#(
   parameter int unsigned   IW       = IW_DEF,
   parameter int unsigned   AW       = AW_DEF,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   risc_fetch_if.master  bus
);
   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          infl_q, infl_d;
   logic [AW-1:0] ifpc_q, ifpc_d;

   logic [IW+AW-1:0] head;
   logic [1:0]       count;
   logic             valid, pop, push, req, credit_ok, halted;

   assign valid = (count != 2'd0);
   assign pop   = valid & ~bus.stall & ~bus.redirect;

`ifdef RISC_FETCH_HALT_EN
   logic halt_hit;
   assign halted   = (state_q == ST_HALT);
   assign halt_hit = push & (bus.imem_rdata == IW'(HALT_WORD));
`else
   assign halted = 1'b0;
`endif

   // Responses landing in HALT or during a redirect are discarded.
   assign push = infl_q & ~bus.redirect & ~halted;

   // Slots left = 2 - occupancy - in-flight, plus the one freed by this pop.
   assign credit_ok = ({1'b0, count} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_BOOT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
`ifdef RISC_FETCH_HALT_EN
            if (!bus.redirect && halt_hit) state_d = ST_HALT;
`endif
         end
`ifdef RISC_FETCH_HALT_EN
         ST_HALT: if (bus.redirect) state_d = ST_RUN;
`endif
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      req = (state_q == ST_RUN) & ~bus.redirect & credit_ok;
   end

   always_comb begin
      pc_d   = pc_q;
      infl_d = req;
      ifpc_d = req ? pc_q : ifpc_q;
      if (bus.redirect) pc_d = bus.redirect_pc;
      else if (req)     pc_d = pc_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         infl_q <= 1'b0;
         ifpc_q <= '0;
      end else begin
         pc_q   <= pc_d;
         infl_q <= infl_d;
         ifpc_q <= ifpc_d;
      end
   end

   risc_fetch_fifo #(.W(IW + AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .wdata ({bus.imem_rdata, ifpc_q}),
      .head  (head),
      .count (count)
   );

   assign bus.imem_req    = req;
   assign bus.imem_addr   = req ? pc_q : '0;
   assign bus.instr_valid = valid;
   assign bus.instr       = valid ? head[IW+AW-1:AW] : '0;
   assign bus.instr_pc    = valid ? head[AW-1:0] : '0;
endmodule

// File: tb/tb_risc_fetch.sv
// Directed, table-driven bench for risc_fetch; memory returns addr+0x100.
module tb_risc_fetch;
   import risc_pkg::*;

   localparam int unsigned IW = 13;
   localparam int unsigned AW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   risc_fetch_if #(.IW(IW), .AW(AW)) bus ();

   risc_fetch #(.IW(IW), .AW(AW), .RESET_PC(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bit hw_en = 1'b0;

   function automatic logic [12:0] mem_word(logic [7:0] a, bit en);
      if (en && a == 8'd3) return 13'h1FFF;
      return 13'h100 + {5'd0, a};
   endfunction

   always @(posedge clk)
      if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr, hw_en);

   typedef struct {
      logic       rst;
      logic       stall;
      logic       redir;
      logic [7:0] rpc;
      logic       req;
      logic [7:0] addr;
      logic       valid;
      logic [7:0] pc;
   } vec_t;

   vec_t tv[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(logic r, logic s, logic d, logic [7:0] rp,
                               logic q, logic [7:0] a, logic v, logic [7:0] p);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = d; t.rpc = rp;
      t.req = q; t.addr = a; t.valid = v; t.pc = p;
      return t;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      int n;
      logic [12:0] exp_instr;

      // rst, stall, redirect, redirect_pc | req, addr, valid, pc
      tv.push_back(mk(1,0,0,8'h00, 0,8'h00, 0,8'h00)); // 0 reset held
      tv.push_back(mk(0,0,0,8'h00, 0,8'h00, 0,8'h00)); // 1 BOOT
      tv.push_back(mk(0,0,0,8'h00, 1,8'h00, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h01, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h02, 1,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h03, 1,8'h01));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h04, 1,8'h02));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h05, 1,8'h03));
      for (int i = 0; i < 5; i++)                       // 8..12 stall
         tv.push_back(mk(0,1,0,8'h00, 0,8'h00, 1,8'h04));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h06, 1,8'h04));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h07, 1,8'h05));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h08, 1,8'h06));
      tv.push_back(mk(0,1,0,8'h00, 0,8'h00, 1,8'h07)); // 16 fill FIFO
      tv.push_back(mk(0,1,1,8'h40, 0,8'h00, 1,8'h07)); // 17 redirect+stall
      tv.push_back(mk(0,0,0,8'h00, 1,8'h40, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h41, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h42, 1,8'h40));
      tv.push_back(mk(0,0,1,8'hFE, 0,8'h00, 1,8'h41)); // 21 drop in-flight
      tv.push_back(mk(0,0,0,8'h00, 1,8'hFE, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'hFF, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h00, 1,8'hFE));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h01, 1,8'hFF));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h02, 1,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h03, 1,8'h01));
      tv.push_back(mk(0,0,1,8'h20, 0,8'h00, 1,8'h02)); // 28 back-to-back
      tv.push_back(mk(0,0,1,8'h30, 0,8'h00, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h30, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h31, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h32, 1,8'h30));
      tv.push_back(mk(1,0,0,8'h00, 1,8'h33, 1,8'h31)); // 33 mid-run reset
      tv.push_back(mk(0,0,0,8'h00, 0,8'h00, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h00, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h01, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h02, 1,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h03, 1,8'h01));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h04, 1,8'h02));
`ifdef RISC_FETCH_HALT_EN
      tv.push_back(mk(0,0,0,8'h00, 0,8'h00, 1,8'h03)); // 40 halt word
      tv.push_back(mk(0,0,0,8'h00, 0,8'h00, 0,8'h00));
      tv.push_back(mk(0,0,1,8'h10, 0,8'h00, 0,8'h00));
`else
      tv.push_back(mk(0,0,0,8'h00, 1,8'h05, 1,8'h03)); // 40 ordinary word
      tv.push_back(mk(0,0,0,8'h00, 1,8'h06, 1,8'h04));
      tv.push_back(mk(0,0,1,8'h10, 0,8'h00, 1,8'h05));
`endif
      tv.push_back(mk(0,0,0,8'h00, 1,8'h10, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h11, 0,8'h00));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h12, 1,8'h10));
      tv.push_back(mk(0,0,0,8'h00, 1,8'h13, 1,8'h11));

      rst = 1'b1;
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 8'h00;
      repeat (2) @(posedge clk);

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         hw_en           = (i >= 34);
         rst             = tv[i].rst;
         bus.stall       = tv[i].stall;
         bus.redirect    = tv[i].redir;
         bus.redirect_pc = tv[i].rpc;
         #1;
         exp_instr = tv[i].valid ? mem_word(tv[i].pc, hw_en) : 13'h0;
         chk("imem_req",    i, 32'(bus.imem_req),    32'(tv[i].req));
         chk("imem_addr",   i, 32'(bus.imem_addr),   32'(tv[i].addr));
         chk("instr_valid", i, 32'(bus.instr_valid), 32'(tv[i].valid));
         chk("instr_pc",    i, 32'(bus.instr_pc),    32'(tv[i].pc));
         chk("instr",       i, 32'(bus.instr),       32'(exp_instr));
      end

      // Redirect under a held stall: latency, then hold with 2 outstanding.
      hw_en = 1'b0;
      @(negedge clk);
      bus.stall = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'h80;
      @(negedge clk);
      bus.redirect = 1'b0;
      #1;
      n = 1;
      while (!bus.instr_valid && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("redir_latency", 0, 32'(n), 32'd3);
      chk("redir_pc",      0, 32'(bus.instr_pc), 32'h80);
      chk("redir_instr",   0, 32'(bus.instr),    32'h180);
      for (int k = 0; k < 3; k++) begin
         chk("stall_req_low", k, 32'(bus.imem_req), 32'd0);
         chk("stall_hold_pc", k, 32'(bus.instr_pc), 32'h80);
         @(negedge clk);
         #1;
      end
      bus.stall = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("release_pc",    k, 32'(bus.instr_pc),    32'(8'h80 + k));
         chk("release_valid", k, 32'(bus.instr_valid), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
